// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hard-wired control sequencer: opcodes, FSM state
// encoding, ALU-op bit positions and instruction field locations.
package cpu_ctrl_pkg;

    // 5-bit opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Sequencer states: fetch T0..T2, execute T3..T6, plus the terminal HALT
    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_HALT = 4'd15
    } state_t;

    // Execution classes produced by the instruction decoder
    typedef enum logic [2:0] {
        CLS_R3      = 3'd0,
        CLS_UNARY   = 3'd1,
        CLS_MULDIV  = 3'd2,
        CLS_NOP     = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    // Bit positions inside the one-hot alu_op bus
    localparam int ALU_W    = 13;
    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_SUB  = 3;
    localparam int ALU_MUL  = 4;
    localparam int ALU_DIV  = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    // Instruction field locations
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    // One-hot register select from a 4-bit register index
    function automatic logic [15:0] reg_sel(input logic [3:0] idx);
        reg_sel = 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: classifies the opcode into an execution
// class, produces the one-hot ALU operation and extracts the register fields.
import cpu_ctrl_pkg::*;

module instr_decoder (
    input  logic [31:0] ir,
    output op_class_t   op_class,
    output logic [12:0] alu_op,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [3:0]  rc
);

    logic [4:0] opcode;
    logic       ir_low_unused;

    assign opcode        = ir[OPC_HI:OPC_LO];
    assign ra            = ir[RA_HI:RA_LO];
    assign rb            = ir[RB_HI:RB_LO];
    assign rc            = ir[RC_HI:RC_LO];
    assign ir_low_unused = ^ir[RC_LO-1:0];

    // Opcode to execution class and ALU operation; anything unlisted is illegal
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_op   = '0;
        case (opcode)
            OP_ADD:  begin op_class = CLS_R3;     alu_op[ALU_ADD]  = 1'b1; end
            OP_SUB:  begin op_class = CLS_R3;     alu_op[ALU_SUB]  = 1'b1; end
            OP_AND:  begin op_class = CLS_R3;     alu_op[ALU_AND]  = 1'b1; end
            OP_OR:   begin op_class = CLS_R3;     alu_op[ALU_OR]   = 1'b1; end
            OP_SHR:  begin op_class = CLS_R3;     alu_op[ALU_SHR]  = 1'b1; end
            OP_SHRA: begin op_class = CLS_R3;     alu_op[ALU_SHRA] = 1'b1; end
            OP_SHL:  begin op_class = CLS_R3;     alu_op[ALU_SHL]  = 1'b1; end
            OP_ROR:  begin op_class = CLS_R3;     alu_op[ALU_ROR]  = 1'b1; end
            OP_ROL:  begin op_class = CLS_R3;     alu_op[ALU_ROL]  = 1'b1; end
            OP_MUL:  begin op_class = CLS_MULDIV; alu_op[ALU_MUL]  = 1'b1; end
            OP_DIV:  begin op_class = CLS_MULDIV; alu_op[ALU_DIV]  = 1'b1; end
            OP_NEG:  begin op_class = CLS_UNARY;  alu_op[ALU_NEG]  = 1'b1; end
            OP_NOT:  begin op_class = CLS_UNARY;  alu_op[ALU_NOT]  = 1'b1; end
            OP_NOP:  op_class = CLS_NOP;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hard-wired control sequencer for the CPU datapath. Holds the T-state
// register and decodes every datapath control line from state and ir.
import cpu_ctrl_pkg::*;

module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic        pc_out,
    output logic        mar_in,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        read,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        zlow_out,
    output logic        zhigh_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic [12:0] alu_op,
    output logic        run,
    output logic        illegal_op
);

    state_t      state;
    op_class_t   op_class;
    logic [12:0] dec_alu;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;

    instr_decoder u_dec (
        .ir       (ir),
        .op_class (op_class),
        .alu_op   (dec_alu),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc)
    );

    // State sequencing; run rises on the first edge out of reset (state stays
    // T0 for that edge) and falls when the sequencer enters HALT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_T0;
            run   <= 1'b0;
        end else if (!run) begin
            if (state != ST_HALT)
                run <= 1'b1;
        end else begin
            case (state)
                ST_T0: state <= ST_T1;
                ST_T1: if (mem_ready) state <= ST_T2;
                ST_T2: state <= ST_T3;
                ST_T3: begin
                    case (op_class)
                        CLS_R3, CLS_UNARY, CLS_MULDIV: state <= ST_T4;
                        CLS_HALT: begin
                            state <= ST_HALT;
                            run   <= 1'b0;
                        end
                        default: state <= ST_T0;
                    endcase
                end
                ST_T4: state <= (op_class == CLS_UNARY) ? ST_T0 : ST_T5;
                ST_T5: state <= (op_class == CLS_MULDIV) ? ST_T6 : ST_T0;
                ST_T6: state <= ST_T0;
                ST_HALT: begin
                    state <= ST_HALT;
                    run   <= 1'b0;
                end
                default: state <= ST_T0;
            endcase
        end
    end

    // Per-state control decode; gated by run so reset and HALT force all zero
    always_comb begin
        reg_in     = '0;
        reg_out    = '0;
        pc_out     = 1'b0;
        mar_in     = 1'b0;
        pc_in      = 1'b0;
        inc_pc     = 1'b0;
        read       = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        zlow_out   = 1'b0;
        zhigh_out  = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        alu_op     = '0;
        illegal_op = 1'b0;
        if (run) begin
            case (state)
                ST_T0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                    inc_pc = 1'b1;
                    pc_in  = 1'b1;
                end
                ST_T1: begin
                    read   = 1'b1;
                    mdr_in = 1'b1;
                end
                ST_T2: begin
                    mdr_out = 1'b1;
                    ir_in   = 1'b1;
                end
                ST_T3: begin
                    case (op_class)
                        CLS_R3: begin
                            reg_out = reg_sel(rb);
                            y_in    = 1'b1;
                        end
                        CLS_UNARY: begin
                            reg_out = reg_sel(rb);
                            alu_op  = dec_alu;
                            z_in    = 1'b1;
                        end
                        CLS_MULDIV: begin
                            reg_out = reg_sel(ra);
                            y_in    = 1'b1;
                        end
                        CLS_ILLEGAL: illegal_op = 1'b1;
                        default: ;
                    endcase
                end
                ST_T4: begin
                    case (op_class)
                        CLS_R3: begin
                            reg_out = reg_sel(rc);
                            alu_op  = dec_alu;
                            z_in    = 1'b1;
                        end
                        CLS_UNARY: begin
                            zlow_out = 1'b1;
                            reg_in   = reg_sel(ra);
                        end
                        CLS_MULDIV: begin
                            reg_out = reg_sel(rb);
                            alu_op  = dec_alu;
                            z_in    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T5: begin
                    case (op_class)
                        CLS_R3: begin
                            zlow_out = 1'b1;
                            reg_in   = reg_sel(ra);
                        end
                        CLS_MULDIV: begin
                            zlow_out = 1'b1;
                            lo_in    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T6: begin
                    if (op_class == CLS_MULDIV) begin
                        zhigh_out = 1'b1;
                        hi_in     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks ADD, NOT, MUL, a stalled fetch,
// an undefined opcode, a mid-instruction reset and HALT, checking every
// control output on each falling edge.
module tb_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic        mem_ready;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        pc_out, mar_in, pc_in, inc_pc;
    logic        read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
    logic [12:0] alu_op;
    logic        run;
    logic        illegal_op;

    int n_cmp = 0;
    int n_err = 0;

    // Single-bit control bundle: {pc_out,mar_in,pc_in,inc_pc,read,mdr_in,
    // mdr_out,ir_in,y_in,z_in,zlow_out,zhigh_out,hi_in,lo_in}
    localparam logic [13:0] C_NONE = 14'h0000;
    localparam logic [13:0] C_T0   = 14'h3C00;
    localparam logic [13:0] C_T1   = 14'h0300;
    localparam logic [13:0] C_T2   = 14'h00C0;
    localparam logic [13:0] C_Y    = 14'h0020;
    localparam logic [13:0] C_Z    = 14'h0010;
    localparam logic [13:0] C_ZL   = 14'h0008;
    localparam logic [13:0] C_ZH   = 14'h0004;
    localparam logic [13:0] C_HI   = 14'h0002;
    localparam logic [13:0] C_LO   = 14'h0001;

    localparam logic [31:0] IR_ADD  = 32'h1A2B8000;
    localparam logic [31:0] IR_NOT  = 32'h920B8000;
    localparam logic [31:0] IR_MUL  = 32'h7A2B8000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .ir         (ir),
        .mem_ready  (mem_ready),
        .reg_in     (reg_in),
        .reg_out    (reg_out),
        .pc_out     (pc_out),
        .mar_in     (mar_in),
        .pc_in      (pc_in),
        .inc_pc     (inc_pc),
        .read       (read),
        .mdr_in     (mdr_in),
        .mdr_out    (mdr_out),
        .ir_in      (ir_in),
        .y_in       (y_in),
        .z_in       (z_in),
        .zlow_out   (zlow_out),
        .zhigh_out  (zhigh_out),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .alu_op     (alu_op),
        .run        (run),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Compare every output against the expected bundle at the current time
    task automatic chk(input string tag, input logic [13:0] c, input logic [15:0] ri,
                       input logic [15:0] ro, input logic [12:0] a,
                       input logic r, input logic il);
        logic [60:0] obs;
        logic [60:0] exp;
        obs = {pc_out, mar_in, pc_in, inc_pc, read, mdr_in, mdr_out, ir_in,
               y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in,
               reg_in, reg_out, alu_op, run, illegal_op};
        exp = {c, ri, ro, a, r, il};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check
    task automatic step(input string tag, input logic [13:0] c, input logic [15:0] ri,
                        input logic [15:0] ro, input logic [12:0] a,
                        input logic r, input logic il);
        @(negedge clk);
        chk(tag, c, ri, ro, a, r, il);
    endtask

    initial begin
        reset     = 1'b0;
        ir        = 32'h0;
        mem_ready = 1'b1;

        // Held in reset: everything quiet
        @(negedge clk);
        step("reset", C_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0);
        ir    = IR_ADD;
        reset = 1'b1;

        // ADD R4,R5,R7: 6 cycles
        step("add_t0", C_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("add_t1", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("add_t2", C_T2, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("add_t3", C_Y,  16'h0, 16'h0020, 13'h0, 1'b1, 1'b0);
        step("add_t4", C_Z,  16'h0, 16'h0080, 13'h0004, 1'b1, 1'b0);
        step("add_t5", C_ZL, 16'h0010, 16'h0, 13'h0, 1'b1, 1'b0);

        // NOT R4,R1: 5 cycles; ir wobbles during fetch
        step("not_t0", C_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        ir = IR_BAD;
        step("not_t1", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        ir = IR_NOT;
        step("not_t2", C_T2, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("not_t3", C_Z,  16'h0, 16'h0002, 13'h1000, 1'b1, 1'b0);
        step("not_t4", C_ZL, 16'h0010, 16'h0, 13'h0, 1'b1, 1'b0);

        // MUL R4,R5: 7 cycles, LO then HI, no register write
        step("mul_t0", C_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        ir = IR_MUL;
        step("mul_t1", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("mul_t2", C_T2, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("mul_t3", C_Y,  16'h0, 16'h0010, 13'h0, 1'b1, 1'b0);
        step("mul_t4", C_Z,  16'h0, 16'h0020, 13'h0010, 1'b1, 1'b0);
        step("mul_t5", C_ZL | C_LO, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("mul_t6", C_ZH | C_HI, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);

        // ADD with three wait cycles in T1: 9 cycles total
        step("stall_t0", C_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        ir        = IR_ADD;
        mem_ready = 1'b0;
        step("stall_t1a", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("stall_t1b", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("stall_t1c", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("stall_t1d", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        mem_ready = 1'b1;
        step("stall_t2", C_T2, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("stall_t3", C_Y,  16'h0, 16'h0020, 13'h0, 1'b1, 1'b0);
        step("stall_t4", C_Z,  16'h0, 16'h0080, 13'h0004, 1'b1, 1'b0);
        step("stall_t5", C_ZL, 16'h0010, 16'h0, 13'h0, 1'b1, 1'b0);

        // Undefined opcode 11111: one-cycle illegal_op, then back to T0
        step("ill_t0", C_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        ir = IR_BAD;
        step("ill_t1", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("ill_t2", C_T2, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("ill_t3", C_NONE, 16'h0, 16'h0, 13'h0, 1'b1, 1'b1);

        // ADD interrupted by reset in T4
        step("rst_t0", C_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        ir = IR_ADD;
        step("rst_t1", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("rst_t2", C_T2, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("rst_t3", C_Y,  16'h0, 16'h0020, 13'h0, 1'b1, 1'b0);
        step("rst_t4", C_Z,  16'h0, 16'h0080, 13'h0004, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_drop", C_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0);
        step("rst_hold", C_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0);
        reset = 1'b1;
        step("rst_rel_t0", C_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);

        // HALT: run falls after T3, stays dark for 20 cycles
        step("halt_t1", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        ir = IR_HALT;
        step("halt_t2", C_T2, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("halt_t3", C_NONE, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            step("halt_hold", C_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0);

        // Reset in HALT, then restart
        #3;
        reset = 1'b0;
        #1;
        chk("halt_rst", C_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0);
        step("halt_rst_hold", C_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0);
        reset = 1'b1;
        step("halt_rel_t0", C_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);
        step("halt_rel_t1", C_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

- Hard-wired control sequencer for the CPU datapath.
- Each instruction steps through fetch (T0–T2) and execute (T3–T6).
- Drives every register-enable, bus-select and ALU-op line that the datapath consumes, replacing hand-driven control.
- Covers the ALU instruction group (R-format three-operand, two-operand unary, MUL/DIV to HI/LO), NOP and HALT; load/store/branch are out of scope.

## Interface
- Parameters: none. All encodings come from cpu_ctrl_pkg.
- Ports:
  - clk  in  1  system clock, all state changes on rising edge
  - reset  in  1  asynchronous, active-low; 0 clears the FSM immediately
  - ir  in  32  instruction register contents from datapath; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
  - mem_ready  in  1  memory read complete; sampled only in T1
  - reg_in  out  16  one-hot R0in..R15in
  - reg_out  out  16  one-hot R0out..R15out
  - pc_out, mar_in, pc_in, inc_pc  out  1 each  PC/MAR controls
  - read, mdr_in, mdr_out, ir_in  out  1 each  memory/IR controls
  - y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in  out  1 each  ALU result path
  - alu_op  out  13  one-hot, bit order AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT (bit 0 = AND)
  - run  out  1  1 while executing, 0 in HALT or under reset
  - illegal_op  out  1  one-cycle pulse on an undefined opcode

## Operation
- Opcodes (5-bit):
  - ADD 00011, SUB 00100, AND 00101, OR 00110
  - SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011
  - MUL 01111, DIV 10000, NEG 10001, NOT 10010
  - NOP 11010, HALT 11011
- States: T0, T1, T2, T3, T4, T5, T6, HALT.
- Outputs are a combinational decode of the registered state and ir. The datapath registers them on the edge that ends the state.
- All outputs not listed for a state are 0.
- Fetch:
  - T0: pc_out, mar_in, inc_pc, pc_in.
  - T1: read, mdr_in. Hold T1 while mem_ready=0.
  - T2: mdr_out, ir_in.
- Execute, decoded from ir in T3:
  - Three-operand: T3 reg_out[Rb], y_in. T4 reg_out[Rc], alu_op[op], z_in. T5 zlow_out, reg_in[Ra]. Then T0.
  - NEG/NOT: T3 reg_out[Rb], alu_op[op], z_in. T4 zlow_out, reg_in[Ra]. Then T0.
  - MUL/DIV: T3 reg_out[Ra], y_in. T4 reg_out[Rb], alu_op[op], z_in. T5 zlow_out, lo_in. T6 zhigh_out, hi_in. Then T0.
  - NOP: T3 drives nothing, then T0.
  - HALT: T3 → HALT. HALT holds all controls at 0 and run=0 until reset.
  - Undefined opcode: behave as NOP and pulse illegal_op in T3.
- reg_in/reg_out are at most one-hot. Register index 4 bits, no wrap or clamp needed.

## Timing
- Reset (reset=0, async): state=T0; every output 0 including run. On the first rising edge after reset=1, run=1 and T0 outputs are active.
- Reset asserted mid-instruction: all enables drop combinationally in the same delta; no partial write is generated after the deassertion edge.
- Cycle count per instruction with mem_ready=1 in T1:
  - three-operand: 6
  - NEG/NOT: 5
  - MUL/DIV: 7
  - NOP or undefined: 4
- Each cycle of mem_ready=0 in T1 adds one cycle. read and mdr_in stay asserted throughout.
- mem_ready outside T1 is ignored.
- ir changes during T0–T2 are ignored. Decode uses ir from T3 onward, once ir_in has taken effect at the end of T2.

## Structure
- cpu_ctrl_pkg:
  - opcode localparams
  - state encoding (4-bit: T0=0 … T6=6, HALT=15)
  - ALU_OP bit indices matching the alu_op order above
  - instruction-field bit ranges
- instr_decoder sub-module (combinational):
  - inputs: ir
  - outputs: op class (R3, UNARY, MULDIV, NOP, HALT, ILLEGAL), one-hot alu_op, Ra/Rb/Rc
- control_unit keeps the state register and the per-state output decode.

## Test plan
- Reset then ir=0x1A2B8000 (ADD R4,R5,R7), mem_ready=1:
  - T3 reg_out=0x0020 with y_in.
  - T4 reg_out=0x0080 with alu_op=0x0004 and z_in.
  - T5 reg_in=0x0010 with zlow_out.
  - Next T0 at cycle 6.
- ir=0x920B8000 (NOT R4,R1): completes in 5 cycles.
  - T3 reg_out=0x0002 with alu_op=0x1000.
  - T4 reg_in=0x0010.
- ir=0x7A2B8000 (MUL R4,R5): 7 cycles; lo_in in T5, hi_in in T6, reg_in never asserted.
- mem_ready low for 3 cycles in T1: read and mdr_in stay high 4 cycles; the ADD then takes 9 cycles total.
- Opcode 11111: illegal_op high for exactly one cycle in T3, no register enable, return to T0.
- ir=0xD8000000 (HALT): run falls after T3, all outputs stay 0 for 20 cycles. Then reset=0 mid-HALT: run=0 until release, T0 outputs active on the first edge.
